// File: rtl/led_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_share_pkg
//  Purpose  : Pattern codes, FSM encodings and LED helper for led_share_arbiter
//  Revision : 1.0  initial release
// ============================================================================
package led_share_pkg;

   localparam logic [1:0] PAT_OFF   = 2'd0;
   localparam logic [1:0] PAT_SOLID = 2'd1;
   localparam logic [1:0] PAT_SLOW  = 2'd2;
   localparam logic [1:0] PAT_FAST  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Blink patterns follow the phase; OFF and SOLID ignore it.
   function automatic logic pat_led(input logic [1:0] pat, input logic phase);
      case (pat)
         PAT_OFF:   pat_led = 1'b0;
         PAT_SOLID: pat_led = 1'b1;
         default:   pat_led = phase;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : led_tick_gen
//  Purpose  : Free-running prescaler, one-cycle tick every CLOCK_FREQ/TICK_HZ
//  Revision : 1.0  initial release
// ============================================================================
module led_tick_gen #(
   parameter int CLOCK_FREQ = 24_000_000,
   parameter int TICK_HZ    = 1000
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int c_div = CLOCK_FREQ / TICK_HZ;
   localparam int c_pw  = (c_div > 1) ? $clog2(c_div) : 1;

   logic [c_pw-1:0] pre_q;
   logic [c_pw-1:0] pre_d;

   assign tick = (pre_q == c_pw'(c_div - 1));

   always_comb begin
      pre_d = tick ? '0 : pre_q + c_pw'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : led_share_arbiter
//  Purpose  : Arbitrates NUM_REQ blink-pattern requesters onto one LED.
//             Optional LED_SHARE_ROUND_ROBIN_EN rotates the priority pointer.
//  Revision : 1.0  initial release
// ============================================================================
module led_share_arbiter
   import led_share_pkg::*;
#(
   parameter int CLOCK_FREQ = 24_000_000,
   parameter int TICK_HZ    = 1000,
   parameter int NUM_REQ    = 4,
   parameter int SLOW_HALF  = 500,
   parameter int FAST_HALF  = 125,
   parameter int GAP_TICKS  = 200
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [2*NUM_REQ-1:0]   pattern,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   led
);

   localparam int c_max_sf = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int c_max_t  = (c_max_sf > GAP_TICKS) ? c_max_sf : GAP_TICKS;
   localparam int c_cnt_w  = $clog2(c_max_t + 1);
   localparam int c_idx_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_sum_w  = c_idx_w + 1;
   localparam logic [NUM_REQ-1:0] c_one = NUM_REQ'(1);

   logic                 tick;

   state_t               state_q,  state_d;
   logic [c_idx_w-1:0]   owner_q,  owner_d;
   logic [1:0]           pat_q,    pat_d;
   logic [c_cnt_w-1:0]   cnt_q,    cnt_d;
   logic                 phase_q,  phase_d;
   logic [NUM_REQ-1:0]   grant_q,  grant_d;
   logic                 busy_q,   busy_d;
   logic                 led_q,    led_d;

   logic [c_idx_w-1:0]   w_base;
   logic [2*NUM_REQ-1:0] w_req_dbl;
   logic [NUM_REQ-1:0]   w_req_rot;
   logic                 w_win_any;
   logic [c_idx_w-1:0]   w_win_idx;
   logic [c_sum_w-1:0]   w_win_sum;
   logic [1:0]           w_win_pat;
   logic                 w_owner_req;
   logic                 w_owner_top;
   logic [1:0]           w_owner_pat;
   logic [c_cnt_w-1:0]   w_half_m1;
   logic                 w_leave;
   logic [c_sum_w-1:0]   w_next_sum;
   logic [c_idx_w-1:0]   w_owner_next;

   led_tick_gen #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .TICK_HZ    (TICK_HZ)
   ) u_tick (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

`ifdef LED_SHARE_ROUND_ROBIN_EN
   logic [c_idx_w-1:0]   ptr_q, ptr_d;
   assign w_base = ptr_q;
`else
   assign w_base = '0;
`endif

   // Search the requests in priority order starting at w_base.
   assign w_req_dbl = {req, req};
   assign w_req_rot = w_req_dbl[w_base +: NUM_REQ];

   always_comb begin
      w_win_any = 1'b0;
      w_win_idx = '0;
      w_win_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_win_any && w_req_rot[k]) begin
            w_win_any = 1'b1;
            w_win_sum = {1'b0, w_base} + c_sum_w'(k);
            w_win_idx = (w_win_sum >= c_sum_w'(NUM_REQ)) ?
                        c_idx_w'(w_win_sum - c_sum_w'(NUM_REQ)) :
                        c_idx_w'(w_win_sum);
         end
      end
   end

   assign w_win_pat    = pattern[{w_win_idx, 1'b0} +: 2];
   assign w_owner_req  = req[owner_q];
   assign w_owner_pat  = pattern[{owner_q, 1'b0} +: 2];
   assign w_owner_top  = w_win_any && (w_win_idx == owner_q);
   assign w_half_m1    = (pat_q == PAT_FAST) ? c_cnt_w'(FAST_HALF - 1) :
                                               c_cnt_w'(SLOW_HALF - 1);
   assign w_next_sum   = {1'b0, owner_q} + c_sum_w'(1);
   assign w_owner_next = (w_next_sum >= c_sum_w'(NUM_REQ)) ? '0 : c_idx_w'(w_next_sum);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      led_d   = led_q;
      w_leave = 1'b0;

      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            led_d   = 1'b0;
            if (w_win_any) begin
               state_d = ST_RUN;
               owner_d = w_win_idx;
               pat_d   = w_win_pat;
               cnt_d   = '0;
               phase_d = 1'b1;
               grant_d = c_one << w_win_idx;
               busy_d  = 1'b1;
               led_d   = pat_led(w_win_pat, 1'b1);
            end
         end

         ST_RUN: begin
            if (!w_owner_req) begin
               w_leave = 1'b1;
            end else if (tick) begin
               if (cnt_q == w_half_m1) begin
                  cnt_d   = '0;
                  phase_d = ~phase_q;
                  // End of the off phase is the period boundary.
                  if (!phase_q) begin
                     if (w_owner_top) begin
                        pat_d = w_owner_pat;
                     end else begin
                        w_leave = 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + c_cnt_w'(1);
               end
            end
            led_d = pat_led(pat_d, phase_d);
            if (w_leave) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               led_d   = 1'b0;
            end
         end

         ST_GAP: begin
            led_d = 1'b0;
            if (tick) begin
               if (cnt_q == c_cnt_w'(GAP_TICKS - 1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  grant_d = '0;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + c_cnt_w'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            grant_d = '0;
            busy_d  = 1'b0;
            led_d   = 1'b0;
         end
      endcase
   end

`ifdef LED_SHARE_ROUND_ROBIN_EN
   always_comb begin
      ptr_d = ptr_q;
      if (w_leave) begin
         ptr_d = w_owner_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         pat_q   <= PAT_OFF;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
   assign led   = led_q;

endmodule
`default_nettype wire
